mpsoc_apb_uart_master: RTL and testbench



---
 rtl/mpsoc_apb_master_pkg.sv | 17 +
 rtl/mpsoc_apb_uart_master.sv | 123 ++++++++++++
 tb/tb_mpsoc_apb_uart_master.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpsoc_apb_master_pkg.sv
// Shared types and helpers for the APB initiator that fronts the UART register file.
package mpsoc_apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_mst_state_t;

  // Width of the wait-state counter; never less than one bit, even with the timeout disabled.
  function automatic int unsigned tmo_cnt_width(input int unsigned timeout_cycles);
    int unsigned w;
    w = $clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mpsoc_apb_uart_master.sv
// APB initiator: turns a valid/ready request into one APB transfer, honouring PREADY,
// reporting PSLVERR and aborting accesses that stall for TIMEOUT_CYCLES cycles.
module mpsoc_apb_uart_master
  import mpsoc_apb_master_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 10,
  parameter int unsigned APB_DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
  output logic                      rsp_valid_o,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [APB_DATA_WIDTH-1:0] PWDATA,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int unsigned          CNT_W    = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic                 TMO_EN   = (TIMEOUT_CYCLES != 0);

  apb_mst_state_t              state_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        timeout_hit;
  logic                        psel_q, penable_q, pwrite_q;
  logic [APB_ADDR_WIDTH-1:0]   paddr_q;
  logic [APB_DATA_WIDTH-1:0]   pwdata_q;
  logic                        rsp_valid_q, rsp_err_q, rsp_timeout_q;
  logic [APB_DATA_WIDTH-1:0]   rsp_rdata_q;

  // Saturating increment; the counter sticks at all-ones rather than wrapping.
  assign cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  // This stalled cycle is the TIMEOUT_CYCLES-th one of the access phase.
  assign timeout_hit = TMO_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: the asynchronous reset lets PSEL/PENABLE fall immediately, without a clock edge.
    if (RST) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; this default makes rsp_valid a one-cycle pulse.
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            pwrite_q <= req_write_i;
            paddr_q  <= req_addr_i;
            pwdata_q <= req_wdata_i;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // PREADY is tested first so a completion in the final allowed cycle beats the abort.
          if (PREADY) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
            rsp_err_q     <= PSLVERR;
            rsp_timeout_q <= 1'b0;
            state_q       <= IDLE;
          end else if (timeout_hit) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign PSEL          = psel_q;
  assign PENABLE       = penable_q;
  assign PWRITE        = pwrite_q;
  assign PADDR         = paddr_q;
  assign PWDATA        = pwdata_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_mpsoc_apb_uart_master.sv
// Directed bench for mpsoc_apb_uart_master against a configurable APB slave that mimics the
// UART register file (LCR at 0x00C resets to 0x03).
module tb_mpsoc_apb_uart_master;

  logic       CLK, RST;
  logic       req_valid_i, req_ready_o, req_write_i;
  logic [9:0] req_addr_i;
  logic [7:0] req_wdata_i;
  logic       rsp_valid_o, rsp_err_o, rsp_timeout_o;
  logic [7:0] rsp_rdata_o;
  logic       PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [9:0] PADDR;
  logic [7:0] PWDATA, PRDATA;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mpsoc_apb_uart_master #(
    .APB_ADDR_WIDTH(10),
    .APB_DATA_WIDTH(8),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Slave model: sl_waits wait states per access, optional PSLVERR, or PREADY stuck low.
  logic [3:0] sl_waits;
  logic       sl_err, sl_stuck;
  logic [3:0] wcnt;
  logic [7:0] regs [0:7];

  assign PREADY  = PSEL && PENABLE && !sl_stuck && (wcnt == sl_waits);
  assign PSLVERR = PREADY && sl_err;
  assign PRDATA  = regs[PADDR[4:2]];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 8; i++) regs[i] <= (i == 3) ? 8'h03 : 8'h00;
      wcnt <= '0;
    end else begin
      if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1'b1;
      else                            wcnt <= '0;
      if (PSEL && PENABLE && PREADY && PWRITE) regs[PADDR[4:2]] <= PWDATA;
    end
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Waits (bounded) for req_ready_o, presents one request for the accept edge; returns in cycle 1.
  task automatic issue(input logic w, input logic [9:0] a, input logic [7:0] d);
    int n = 0;
    while (!req_ready_o && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL issue_ready: req_ready_o=%0b required 1", req_ready_o);
    end
    req_valid_i = 1'b1;
    req_write_i = w;
    req_addr_i  = a;
    req_wdata_i = d;
    cyc = 0;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int maxc, output int at);
    at = -1;
    while (at < 0 && cyc <= maxc) begin
      if (rsp_valid_o) at = cyc;
      else tick();
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #1;
    total++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== 21'd0) begin
      bad++;
      $display("FAIL reset_apb: got %0h required 0", {PSEL, PENABLE, PWRITE, PADDR, PWDATA});
    end
    total++;
    if ({rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== 11'd0) begin
      bad++;
      $display("FAIL reset_rsp: got %0h required 0",
               {rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o});
    end
    repeat (3) tick();
    RST = 1'b0;
    tick();
    total++;
    if (req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %0b required 1", req_ready_o);
    end
  endtask

  task automatic test_write_zero_wait();
    logic exp_psel [3] = '{1'b1, 1'b1, 1'b0};
    logic exp_pen  [3] = '{1'b0, 1'b1, 1'b0};
    logic exp_vld  [3] = '{1'b0, 1'b0, 1'b1};
    logic exp_rdy  [3] = '{1'b0, 1'b0, 1'b1};
    sl_waits = 0; sl_err = 0; sl_stuck = 0;
    issue(1'b1, 10'h00C, 8'h83);
    for (int c = 1; c <= 3; c++) begin
      total++;
      if ({PSEL, PENABLE, rsp_valid_o, req_ready_o} !==
          {exp_psel[c-1], exp_pen[c-1], exp_vld[c-1], exp_rdy[c-1]}) begin
        bad++;
        $display("FAIL wr_ctrl cycle %0d: psel/pen/vld/rdy=%b required %b", c,
                 {PSEL, PENABLE, rsp_valid_o, req_ready_o},
                 {exp_psel[c-1], exp_pen[c-1], exp_vld[c-1], exp_rdy[c-1]});
      end
      total++;
      if (c < 3 && {PWRITE, PADDR, PWDATA} !== {1'b1, 10'h00C, 8'h83}) begin
        bad++;
        $display("FAIL wr_bus cycle %0d: pwrite/paddr/pwdata=%0h required %0h", c,
                 {PWRITE, PADDR, PWDATA}, {1'b1, 10'h00C, 8'h83});
      end
      if (c < 3) tick();
    end
    total++;
    if ({rsp_err_o, rsp_timeout_o, rsp_rdata_o} !== 10'd0) begin
      bad++;
      $display("FAIL wr_rsp: err/tmo/rdata=%0h required 0", {rsp_err_o, rsp_timeout_o, rsp_rdata_o});
    end
  endtask

  task automatic test_read_wait();
    int at;
    logic addr_ok = 1'b1;
    issue(1'b1, 10'h014, 8'h60);
    wait_rsp(5, at);
    sl_waits = 4;
    issue(1'b0, 10'h014, 8'h00);
    at = -1;
    while (at < 0 && cyc <= 12) begin
      if (rsp_valid_o) at = cyc;
      else begin
        if (PADDR !== 10'h014 || PSEL !== 1'b1) addr_ok = 1'b0;
        tick();
      end
    end
    total++;
    if (at != 7) begin
      bad++;
      $display("FAIL rd_wait_latency: rsp_valid at cycle %0d required 7", at);
    end
    total++;
    if (addr_ok !== 1'b1) begin
      bad++;
      $display("FAIL rd_wait_paddr: paddr/psel not stable over cycles 1-6, got ok=%0b required 1", addr_ok);
    end
    total++;
    if ({rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== {8'h60, 2'b00}) begin
      bad++;
      $display("FAIL rd_wait_rsp: rdata/err/tmo=%0h required %0h",
               {rsp_rdata_o, rsp_err_o, rsp_timeout_o}, {8'h60, 2'b00});
    end
    sl_waits = 0;
  endtask

  task automatic test_slverr();
    int at;
    sl_waits = 1; sl_err = 1;
    issue(1'b1, 10'h008, 8'h55);
    wait_rsp(8, at);
    total++;
    if (at != 4 || rsp_err_o !== 1'b1 || rsp_timeout_o !== 1'b0) begin
      bad++;
      $display("FAIL slverr_rsp: cycle=%0d err=%0b tmo=%0b required cycle=4 err=1 tmo=0",
               at, rsp_err_o, rsp_timeout_o);
    end
    tick();
    total++;
    if (rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b1) begin
      bad++;
      $display("FAIL slverr_hold: vld=%0b err=%0b required vld=0 err=1", rsp_valid_o, rsp_err_o);
    end
    sl_waits = 0; sl_err = 0;
    issue(1'b0, 10'h014, 8'h00);
    wait_rsp(6, at);
    total++;
    if (at != 3 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 8'h60) begin
      bad++;
      $display("FAIL slverr_next: cycle=%0d err=%0b rdata=%0h required cycle=3 err=0 rdata=60",
               at, rsp_err_o, rsp_rdata_o);
    end
  endtask

  task automatic test_timeout();
    int at;
    sl_stuck = 1;
    issue(1'b0, 10'h014, 8'h00);
    wait_rsp(20, at);
    total++;
    if (at != 10) begin
      bad++;
      $display("FAIL tmo_latency: rsp_valid at cycle %0d required 10", at);
    end
    total++;
    if ({rsp_err_o, rsp_timeout_o, rsp_rdata_o, PSEL, PENABLE} !== {2'b11, 8'h00, 2'b00}) begin
      bad++;
      $display("FAIL tmo_rsp: err/tmo/rdata/psel/pen=%0h required %0h",
               {rsp_err_o, rsp_timeout_o, rsp_rdata_o, PSEL, PENABLE}, {2'b11, 8'h00, 2'b00});
    end
    sl_stuck = 0; sl_waits = 7;
    issue(1'b0, 10'h014, 8'h00);
    wait_rsp(20, at);
    total++;
    if (at != 10 || {rsp_err_o, rsp_timeout_o, rsp_rdata_o} !== {2'b00, 8'h60}) begin
      bad++;
      $display("FAIL tmo_last_ready: cycle=%0d err/tmo/rdata=%0h required cycle=10 %0h",
               at, {rsp_err_o, rsp_timeout_o, rsp_rdata_o}, {2'b00, 8'h60});
    end
    sl_waits = 0;
  endtask

  task automatic test_reset_mid();
    int at;
    logic seen = 1'b0;
    sl_stuck = 1;
    issue(1'b0, 10'h014, 8'h00);
    tick();
    tick();
    total++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      bad++;
      $display("FAIL rstmid_access: psel/pen=%b required 11", {PSEL, PENABLE});
    end
    #2;
    RST = 1'b1;
    #1;
    total++;
    if ({PSEL, PENABLE} !== 2'b00) begin
      bad++;
      $display("FAIL rstmid_async: psel/pen=%b required 00", {PSEL, PENABLE});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid_o) seen = 1'b1;
    end
    RST = 1'b0;
    sl_stuck = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid_o) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || rsp_rdata_o !== 8'h00) begin
      bad++;
      $display("FAIL rstmid_norsp: pulse_seen=%0b rdata=%0h required 0 00", seen, rsp_rdata_o);
    end
    issue(1'b0, 10'h00C, 8'h00);
    wait_rsp(6, at);
    total++;
    if (at != 3 || rsp_rdata_o !== 8'h03) begin
      bad++;
      $display("FAIL rstmid_lcr: cycle=%0d rdata=%0h required cycle=3 rdata=03", at, rsp_rdata_o);
    end
  endtask

  task automatic test_back_to_back();
    logic       bw [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [9:0] ba [5] = '{10'h000, 10'h004, 10'h000, 10'h004, 10'h00C};
    logic [7:0] bd [5] = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00};
    logic [7:0] be [5] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h03};
    int idx = 0, nrsp = 0, last = -1, extra = 0;
    logic acc;
    tick();
    cyc = 0;
    req_valid_i = 1'b1;
    req_write_i = bw[0]; req_addr_i = ba[0]; req_wdata_i = bd[0];
    while (nrsp < 5 && cyc < 60) begin
      acc = req_valid_i && req_ready_o;
      tick();
      if (acc) begin
        idx++;
        if (idx < 5) begin
          req_write_i = bw[idx]; req_addr_i = ba[idx]; req_wdata_i = bd[idx];
        end else req_valid_i = 1'b0;
      end
      if (rsp_valid_o) begin
        total++;
        if (rsp_rdata_o !== be[nrsp]) begin
          bad++;
          $display("FAIL b2b_data[%0d]: rdata=%0h required %0h", nrsp, rsp_rdata_o, be[nrsp]);
        end
        if (last >= 0) begin
          total++;
          if (cyc - last != 3) begin
            bad++;
            $display("FAIL b2b_spacing[%0d]: gap=%0d required 3", nrsp, cyc - last);
          end
        end
        last = cyc;
        nrsp++;
      end
    end
    req_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid_o) extra++;
    end
    total++;
    if (nrsp + extra != 5) begin
      bad++;
      $display("FAIL b2b_count: pulses=%0d required 5", nrsp + extra);
    end
  endtask

  initial begin
    req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    sl_waits = 0; sl_err = 0; sl_stuck = 0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
